// File: rtl/tusca_pkg.sv
// Shared types, constants and helpers for the TUSCA telemetry transmitter.
// Byte framing depends on TUSCA_TX_PARIDADE_EN (8E1 when defined, 8N1 otherwise).
package tusca_pkg;

   localparam logic [7:0] ASC_U  = 8'h55;
   localparam logic [7:0] ASC_T  = 8'h54;
   localparam logic [7:0] ASC_LF = 8'h0A;

   localparam int unsigned FRAME_BYTES = 7;
   localparam int unsigned BYTE_IDX_W  = 3;
   localparam logic [BYTE_IDX_W-1:0] ULTIMO_BYTE = BYTE_IDX_W'(FRAME_BYTES - 1);

   // Line bits per byte: start + 8 data + optional parity + stop
`ifdef TUSCA_TX_PARIDADE_EN
   localparam int unsigned BITS_POR_BYTE = 11;
`else
   localparam int unsigned BITS_POR_BYTE = 10;
`endif
   localparam int unsigned BIT_IDX_W = 4;

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CARREGA = 2'd1,
      ESPERA  = 2'd2,
      FIM     = 2'd3
   } estado_t;

   typedef struct packed {
      logic [7:0] umidade;
      logic [7:0] temperatura;
   } leitura_t;

   // Uppercase ASCII hex digit for one nibble
   function automatic logic [7:0] hex_ascii(input logic [3:0] n);
      logic [7:0] r;
      if (n < 4'd10) r = 8'h30 + {4'h0, n};
      else           r = 8'h37 + {4'h0, n};
      return r;
   endfunction

   // Frame byte at position idx: 'U' HH 'T' HH LF
   function automatic logic [7:0] frame_byte(input logic [BYTE_IDX_W-1:0] idx,
                                             input leitura_t l);
      logic [7:0] r;
      case (idx)
         3'd0:    r = ASC_U;
         3'd1:    r = hex_ascii(l.umidade[7:4]);
         3'd2:    r = hex_ascii(l.umidade[3:0]);
         3'd3:    r = ASC_T;
         3'd4:    r = hex_ascii(l.temperatura[7:4]);
         3'd5:    r = hex_ascii(l.temperatura[3:0]);
         default: r = ASC_LF;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// Serializes one byte as start, 8 data bits LSB first, optional even parity, stop.
// Parity framing is selected by TUSCA_TX_PARIDADE_EN.
module uart_tx_byte
   import tusca_pkg::*;
#(
   parameter int unsigned CICLOS_BIT = 434
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       partida,
   input  logic [7:0] dado,
   output logic       tx_serial,
   output logic       fim
);

   localparam int unsigned CW = $clog2(CICLOS_BIT);
   localparam int unsigned SW = BITS_POR_BYTE - 1;

   logic                 ativo;
   logic [CW-1:0]        cnt;
   logic [BIT_IDX_W-1:0] bit_idx;
   logic [SW-1:0]        shreg;
   logic                 fim_bit;

   assign fim_bit = (cnt == CW'(CICLOS_BIT - 1));

   // Combinational so a new partida lands on the very next cycle with no gap
   assign fim = ativo && fim_bit && (bit_idx == BIT_IDX_W'(BITS_POR_BYTE - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ativo     <= 1'b0;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '1;
         tx_serial <= 1'b1;
      end else if (partida) begin
         ativo     <= 1'b1;
         cnt       <= '0;
         bit_idx   <= '0;
         tx_serial <= 1'b0;
`ifdef TUSCA_TX_PARIDADE_EN
         shreg     <= {1'b1, ^dado, dado};
`else
         shreg     <= {1'b1, dado};
`endif
      end else if (ativo) begin
         if (fim_bit) begin
            cnt <= '0;
            if (fim) begin
               ativo     <= 1'b0;
               tx_serial <= 1'b1;
            end else begin
               bit_idx   <= BIT_IDX_W'(bit_idx + 1'b1);
               tx_serial <= shreg[0];
               shreg     <= {1'b1, shreg[SW-1:1]};
            end
         end else begin
            cnt <= CW'(cnt + 1'b1);
         end
      end
   end

endmodule

// File: rtl/tusca_tx_telemetria.sv
// Sends a 7-byte ASCII telemetry frame ('U' HH 'T' HH LF) over UART on request.
// Define TUSCA_TX_PARIDADE_EN for 8E1 framing; default is 8N1.
module tusca_tx_telemetria
   import tusca_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 50_000_000,
   parameter int unsigned BAUD     = 115200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enviar,
   input  logic [7:0] umidade,
   input  logic [7:0] temperatura,
   output logic       tx_serial,
   output logic       ocupado,
   output logic       pronto
);

   localparam int unsigned CICLOS_BIT = CLK_FREQ / BAUD;

   estado_t               estado, estado_d;
   logic [BYTE_IDX_W-1:0] idx, idx_d, idx_prox;
   leitura_t              leitura;
   logic                  captura_c;
   logic                  partida_c;
   logic [7:0]            dado_c;
   logic                  fim_byte;
   logic                  ocupado_d, pronto_d;

   assign idx_prox = BYTE_IDX_W'(idx + 1'b1);

   // State, index, snapshot and registered status outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado  <= OCIOSO;
         idx     <= '0;
         leitura <= '0;
         ocupado <= 1'b0;
         pronto  <= 1'b0;
      end else begin
         estado  <= estado_d;
         idx     <= idx_d;
         ocupado <= ocupado_d;
         pronto  <= pronto_d;
         if (captura_c) leitura <= {umidade, temperatura};
      end
   end

   // Next-state; byte loads coincide with the last stop-bit cycle so bytes abut
   always_comb begin
      estado_d  = estado;
      idx_d     = idx;
      captura_c = 1'b0;
      partida_c = 1'b0;
      dado_c    = ASC_U;
      ocupado_d = ocupado;
      pronto_d  = 1'b0;
      case (estado)
         OCIOSO, FIM: begin
            ocupado_d = 1'b0;
            estado_d  = OCIOSO;
            if (enviar) begin
               captura_c = 1'b1;
               partida_c = 1'b1;
               dado_c    = ASC_U;
               idx_d     = '0;
               ocupado_d = 1'b1;
               estado_d  = CARREGA;
            end
         end
         CARREGA: begin
            estado_d = ESPERA;
         end
         ESPERA: begin
            if (fim_byte) begin
               if (idx == ULTIMO_BYTE) begin
                  pronto_d  = 1'b1;
                  ocupado_d = 1'b0;
                  estado_d  = FIM;
               end else begin
                  partida_c = 1'b1;
                  dado_c    = frame_byte(idx_prox, leitura);
                  idx_d     = idx_prox;
                  estado_d  = CARREGA;
               end
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   uart_tx_byte #(
      .CICLOS_BIT(CICLOS_BIT)
   ) u_byte (
      .clock     (clock),
      .reset     (reset),
      .partida   (partida_c),
      .dado      (dado_c),
      .tx_serial (tx_serial),
      .fim       (fim_byte)
   );

endmodule
